sseg_scan_controller: RTL and testbench

SSEG_SCAN_CONTROLLER -- requirements
Module: sseg_scan_controller

---
 rtl/sseg_scan_controller_if.sv | 26 ++
 rtl/sseg_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_sseg_scan_controller.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sseg_scan_controller_if.sv
// rtl/sseg_scan_controller_if.sv - display buffer load channel (value, decimal points, load/ack handshake)
//
// value_in  [15:0] four hex nibbles, nibble k is digit k (digit 0 rightmost)
// dp_in     [3:0]  decimal-point request per digit, 1 = lit
// load             capture request, held by the master until load_ack
// load_ack         one-cycle pulse from the slave confirming capture
interface sseg_scan_controller_if;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        load_ack;

    modport master (
        output value_in,
        output dp_in,
        output load,
        input  load_ack
    );

    modport slave (
        input  value_in,
        input  dp_in,
        input  load,
        output load_ack
    );
endinterface

// File: rtl/sseg_scan_controller.sv
// rtl/sseg_scan_controller.sv - four-digit multiplexed seven-segment scan controller
//
// clk       single clock, rising edge
// reset     synchronous, active-high
// ld        load channel (slave): value_in/dp_in/load in, load_ack out
// digit_en  per-digit enable, 0 keeps the digit dark
// lz_blank  leading-zero suppression enable
// select    index of the digit currently scanned
// anode     active-low digit strobes
// seg       active-low segments {g,f,e,d,c,b,a}
// dp        active-low decimal point
module sseg_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    sseg_scan_controller_if.slave       ld,
    input  logic [3:0]                  digit_en,
    input  logic                        lz_blank,
    output logic [1:0]                  select,
    output logic [3:0]                  anode,
    output logic [6:0]                  seg,
    output logic                        dp
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DRV_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    idx, idx_nx;
    logic          frame_end;

    logic [15:0]   buf_val;
    logic [3:0]    buf_dp;
    logic          ack_q;
    logic [3:0]    en_q;
    logic          lz_q;

    logic [3:0]    nib;
    logic [3:0]    sup;
    logic [6:0]    hex_seg;
    logic          dark;

    // Slot sequencing. frame_end marks the edge that leaves DRIVE of digit 3,
    // the only point where the display buffer may change.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + CW'(1);
        idx_nx    = idx;
        frame_end = 1'b0;
        case (state)
            ST_BLANK: begin
                // With no blank time this state is only seen straight out of reset.
                if (BLANK_CYCLES == 0 || cnt == BLK_LAST) begin
                    state_nx = ST_DRIVE;
                    cnt_nx   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt == DRV_LAST) begin
                    cnt_nx    = '0;
                    idx_nx    = idx + 2'd1;
                    state_nx  = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
                    frame_end = (idx == 2'd3);
                end
            end
            default: begin
                state_nx = ST_BLANK;
                cnt_nx   = '0;
            end
        endcase
    end

    // digit_en and lz_blank are registered every cycle so that no input
    // reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_BLANK;
            cnt     <= '0;
            idx     <= 2'd0;
            buf_val <= 16'h0000;
            buf_dp  <= 4'h0;
            ack_q   <= 1'b0;
            en_q    <= 4'h0;
            lz_q    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            en_q  <= digit_en;
            lz_q  <= lz_blank;
            ack_q <= frame_end && ld.load;
            if (frame_end && ld.load) begin
                buf_val <= ld.value_in;
                buf_dp  <= ld.dp_in;
            end
        end
    end

    assign ld.load_ack = ack_q;

    // A digit is suppressed when it and every digit to its left carry a zero
    // nibble and no decimal point; digit 0 always shows.
    always_comb begin
        sup    = 4'b0000;
        sup[3] = (buf_val[15:12] == 4'h0) && !buf_dp[3];
        sup[2] = sup[3] && (buf_val[11:8] == 4'h0) && !buf_dp[2];
        sup[1] = sup[2] && (buf_val[7:4]  == 4'h0) && !buf_dp[1];
    end

    always_comb begin
        nib = 4'h0;
        case (idx)
            2'd0: nib = buf_val[3:0];
            2'd1: nib = buf_val[7:4];
            2'd2: nib = buf_val[11:8];
            2'd3: nib = buf_val[15:12];
            default: nib = 4'h0;
        endcase
    end

    always_comb begin
        hex_seg = 7'b1111111;
        case (nib)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            4'hF: hex_seg = 7'b0001110;
            default: hex_seg = 7'b1111111;
        endcase
    end

    always_comb begin
        dark   = (state == ST_BLANK) || !en_q[idx] || (lz_q && sup[idx]);
        select = idx;
        anode  = dark ? 4'b1111 : ~(4'b0001 << idx);
        seg    = dark ? 7'b1111111 : hex_seg;
        dp     = dark ? 1'b1 : ~buf_dp[idx];
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// tb/tb_sseg_scan_controller.sv - scoreboard bench for sseg_scan_controller
module tb_sseg_scan_controller;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S3  = 7'b0110000;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S8  = 7'b0000000;
    localparam logic [6:0] SA  = 7'b0001000;
    localparam logic [6:0] SF  = 7'b0001110;
    localparam logic [6:0] OFF = 7'b1111111;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sg;
        logic       d;
        logic [1:0] sel;
        logic       ack;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit_en;
    logic       lz_blank;
    logic [1:0] select;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    exp_t q[$];

    sseg_scan_controller_if ld_if ();

    sseg_scan_controller #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ld       (ld_if),
        .digit_en (digit_en),
        .lz_blank (lz_blank),
        .select   (select),
        .anode    (anode),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle, compared away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        cyc <= cyc + 1;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests = tests + 1;
            if (anode !== e.an || seg !== e.sg || dp !== e.d || select !== e.sel ||
                ld_if.load_ack !== e.ack) begin
                fails = fails + 1;
                $display("FAIL cycle%0d: got an=%b seg=%b dp=%b sel=%0d ack=%b, expected an=%b seg=%b dp=%b sel=%0d ack=%b",
                         cyc, anode, seg, dp, select, ld_if.load_ack,
                         e.an, e.sg, e.d, e.sel, e.ack);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_off(input logic [1:0] sel, input logic ack);
        exp_t e;
        e.an = 4'b1111; e.sg = OFF; e.d = 1'b1; e.sel = sel; e.ack = ack;
        q.push_back(e);
    endtask

    // One 24-cycle frame: per digit 2 blank cycles then 4 drive cycles.
    // dark marks digits expected off in their slot, dplit marks expected lit points.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dark, input logic [3:0] dplit,
                              input logic ack0);
        logic [6:0] segs [4];
        logic [3:0] ans  [4];
        exp_t e;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        ans[0] = 4'b1110; ans[1] = 4'b1101; ans[2] = 4'b1011; ans[3] = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            push_off(2'(k), (k == 0) ? ack0 : 1'b0);
            push_off(2'(k), 1'b0);
            for (int j = 0; j < 4; j++) begin
                e.sel = 2'(k);
                e.ack = 1'b0;
                if (dark[k]) begin
                    e.an = 4'b1111; e.sg = OFF; e.d = 1'b1;
                end else begin
                    e.an = ans[k]; e.sg = segs[k]; e.d = ~dplit[k];
                end
                q.push_back(e);
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        ld_if.load      = 1'b0;
        ld_if.value_in  = 16'h0000;
        ld_if.dp_in     = 4'h0;
        digit_en        = 4'b1111;
        lz_blank        = 1'b0;

        // Held in reset: everything off, no ack.
        step(3);
        push_off(2'd0, 1'b0);
        step(1);
        reset = 1'b0;

        // F0: buffer 0 after reset; request load of 0x1234 mid-frame.
        push_frame(S0, S0, S0, S0, 4'b0000, 4'b0000, 1'b0);
        step(11);
        ld_if.value_in = 16'h1234;
        ld_if.dp_in    = 4'h0;
        ld_if.load     = 1'b1;
        step(13);

        // F1: ack on first cycle, new value from digit 0.
        ld_if.load = 1'b0;
        push_frame(S4, S3, S2, S1, 4'b0000, 4'b0000, 1'b1);
        step(24);

        // F2: load raised then dropped before the boundary.
        push_frame(S4, S3, S2, S1, 4'b0000, 4'b0000, 1'b0);
        step(8);
        ld_if.value_in = 16'h5678;
        ld_if.load     = 1'b1;
        step(12);
        ld_if.load = 1'b0;
        step(4);

        // F3: unchanged, then load of 0x0040 held across two boundaries.
        push_frame(S4, S3, S2, S1, 4'b0000, 4'b0000, 1'b0);
        step(5);
        ld_if.value_in = 16'h0040;
        ld_if.dp_in    = 4'h0;
        ld_if.load     = 1'b1;
        step(19);

        // F4: first ack, no suppression.
        push_frame(S0, S4, S0, S0, 4'b0000, 4'b0000, 1'b1);
        step(24);

        // F5: second ack 24 cycles later; leading zeros suppressed.
        ld_if.load = 1'b0;
        lz_blank   = 1'b1;
        push_frame(S0, S4, S0, S0, 4'b1100, 4'b0000, 1'b1);
        step(24);

        // F6: digit 2 disabled, frame length unchanged; reset hits the next boundary with load high.
        lz_blank = 1'b0;
        digit_en = 4'b1011;
        push_frame(S0, S4, S0, S0, 4'b0100, 4'b0000, 1'b0);
        step(23);
        reset          = 1'b1;
        ld_if.value_in = 16'hFFFF;
        ld_if.dp_in    = 4'hF;
        ld_if.load     = 1'b1;
        step(1);

        // F7: capture discarded, buffer 0, restart; then load 0xA8F1 with points on digits 0 and 2.
        reset          = 1'b0;
        digit_en       = 4'b1111;
        ld_if.value_in = 16'hA8F1;
        ld_if.dp_in    = 4'b0101;
        push_frame(S0, S0, S0, S0, 4'b0000, 4'b0000, 1'b0);
        step(24);

        // F8: hex codes 1, F, 8, A and decimal points.
        ld_if.load = 1'b0;
        push_frame(S1, SF, S8, SA, 4'b0000, 4'b0101, 1'b1);
        step(24);

        step(1);
        tests = tests + 1;
        if (q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, expected completion before 100000 time units");
        $fatal(1, "watchdog");
    end

endmodule
